// File: rtl/my_nios_pio_pkg.sv
// Shared constants and types for the my_nios output PIO slave.
package my_nios_pio_pkg;
  localparam int PULSE_LEN_W = 16;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  typedef enum logic {IDLE, ACTIVE} pulse_state_t;
endpackage

// File: rtl/my_nios_pio_pulse_timer.sv
// One-shot pulse engine: holds the inversion mask for len cycles after a start.
// mask_nxt exposes the post-edge mask so the output register sees it the same cycle.
module my_nios_pio_pulse_timer
  import my_nios_pio_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [W-1:0]           start_mask,
  input  logic [PULSE_LEN_W-1:0] len,
  output logic [W-1:0]           mask,
  output logic [W-1:0]           mask_nxt
);
  pulse_state_t           state_q, state_nxt;
  logic [W-1:0]           mask_q;
  logic [PULSE_LEN_W-1:0] cnt_q, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      mask_q  <= mask_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // A start on the terminal-count edge wins and reloads the full length.
  always_comb begin
    state_nxt = state_q;
    mask_nxt  = mask_q;
    cnt_nxt   = cnt_q;
    if (start) begin
      mask_nxt  = mask_q | start_mask;
      cnt_nxt   = len;
      state_nxt = ACTIVE;
    end else if (state_q == ACTIVE) begin
      if (cnt_q == PULSE_LEN_W'(1)) begin
        mask_nxt  = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        cnt_nxt = cnt_q - PULSE_LEN_W'(1);
      end
    end
  end

  always_comb begin
    mask = mask_q;
  end
endmodule

// File: rtl/my_nios_pio_out.sv
// Avalon-MM output PIO with set/clear and hardware pulse; read latency 1, no waitrequest.
// out_port reflects a write on the edge that samples it.
module my_nios_pio_out
  import my_nios_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter logic [15:0]           PULSE_LEN_RESET = 16'd1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);
  logic                   wr;
  logic [DATA_WIDTH-1:0]  wd;
  logic [DATA_WIDTH-1:0]  data_q, data_nxt;
  logic [PULSE_LEN_W-1:0] len_q;
  logic                   start;
  logic [DATA_WIDTH-1:0]  mask, mask_nxt;
  logic [31:0]            rd_nxt;
  logic                   unused_wd;

  assign wr        = chipselect && !write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign start     = wr && (address == ADDR_PULSE) && (len_q != '0) && (wd != '0);
  assign unused_wd = ^writedata[31:16];

  my_nios_pio_pulse_timer #(.W(DATA_WIDTH)) u_pulse (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_mask (wd),
    .len        (len_q),
    .mask       (mask),
    .mask_nxt   (mask_nxt)
  );

  always_comb begin
    data_nxt = data_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_nxt = wd;
        ADDR_OUTSET:   data_nxt = data_q | wd;
        ADDR_OUTCLEAR: data_nxt = data_q & ~wd;
        default:       data_nxt = data_q;
      endcase
    end
  end

  // Reads see the registers as they were before this edge's write.
  always_comb begin
    rd_nxt = '0;
    case (address)
      ADDR_DATA:      rd_nxt[DATA_WIDTH-1:0]  = data_q;
      ADDR_PULSE_LEN: rd_nxt[PULSE_LEN_W-1:0] = len_q;
      ADDR_PULSE:     rd_nxt[DATA_WIDTH-1:0]  = mask;
      default:        rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      len_q    <= PULSE_LEN_RESET;
      out_port <= RESET_VALUE;
      readdata <= '0;
    end else begin
      data_q   <= data_nxt;
      out_port <= data_nxt ^ mask_nxt;
      readdata <= rd_nxt;
      if (wr && address == ADDR_PULSE_LEN)
        len_q <= writedata[PULSE_LEN_W-1:0];
    end
  end
endmodule

// File: tb/tb_my_nios_pio_out.sv
// Scoreboard bench for my_nios_pio_out: driver queues expected post-edge values, monitor checks them.
module tb_my_nios_pio_out;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  typedef struct {
    bit          co;
    logic [7:0]  eo;
    bit          cr;
    logic [31:0] er;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  my_nios_pio_out #(
    .DATA_WIDTH      (8),
    .RESET_VALUE     (8'h5A),
    .PULSE_LEN_RESET (16'd1000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.co) begin
        total++;
        if (out_port !== e.eo) begin
          bad++;
          $display("FAIL %s out_port: got %h want %h", e.nm, out_port, e.eo);
        end
      end
      if (e.cr) begin
        total++;
        if (readdata !== e.er) begin
          bad++;
          $display("FAIL %s readdata: got %h want %h", e.nm, readdata, e.er);
        end
      end
    end
  end

  // One clock: drive inputs, take the edge, queue what must be visible after it.
  task automatic cyc(input logic rst, input logic [2:0] a, input logic w, input logic [31:0] d,
                     input bit co, input logic [7:0] eo, input bit cr, input logic [31:0] er,
                     input string nm);
    exp_t x;
    reset_n    = rst;
    address    = a;
    chipselect = w;
    write_n    = !w;
    writedata  = d;
    @(posedge clk);
    x.co = co; x.eo = eo; x.cr = cr; x.er = er; x.nm = nm;
    sbq.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // reset state
    cyc(0, 0, 0, 0, 1, 8'h5A, 1, 32'h0, "reset");
    cyc(0, 2, 0, 0, 1, 8'h5A, 1, 32'h0, "reset_rd");
    cyc(1, 2, 0, 0, 1, 8'h5A, 1, 32'd1000, "len_reset");
    cyc(1, 0, 0, 0, 1, 8'h5A, 1, 32'h5A, "data_reset");

    // data, set, clear, reserved
    cyc(1, 0, 1, 32'h0F, 1, 8'h0F, 1, 32'h5A, "data_wr");
    cyc(1, 4, 1, 32'hC0, 1, 8'hCF, 1, 32'h0, "outset");
    cyc(1, 5, 1, 32'h03, 1, 8'hCC, 1, 32'h0, "outclear");
    cyc(1, 0, 0, 0, 1, 8'hCC, 1, 32'hCC, "data_rd");
    cyc(1, 1, 1, 32'hFF, 1, 8'hCC, 1, 32'h0, "rsvd1_wr");
    cyc(1, 7, 1, 32'hFF, 1, 8'hCC, 1, 32'h0, "rsvd7_wr");

    // single pulse, length 4
    cyc(1, 2, 1, 32'd4, 1, 8'hCC, 1, 32'd1000, "len4_wr");
    cyc(1, 2, 0, 0, 0, 8'h00, 1, 32'd4, "len4_rd");
    cyc(1, 0, 1, 32'h00, 1, 8'h00, 0, 32'h0, "data0");
    cyc(1, 3, 1, 32'h01, 1, 8'h01, 1, 32'h0, "pulse_k");
    cyc(1, 3, 0, 0, 1, 8'h01, 1, 32'h1, "pulse_k1");
    cyc(1, 3, 0, 0, 1, 8'h01, 1, 32'h1, "pulse_k2");
    cyc(1, 3, 0, 0, 1, 8'h01, 1, 32'h1, "pulse_k3");
    cyc(1, 3, 0, 0, 1, 8'h00, 1, 32'h1, "pulse_k4");
    cyc(1, 3, 0, 0, 1, 8'h00, 1, 32'h0, "pulse_k5");

    // extended pulse, length 10
    cyc(1, 2, 1, 32'd10, 1, 8'h00, 0, 32'h0, "len10_wr");
    cyc(1, 3, 1, 32'h01, 1, 8'h01, 0, 32'h0, "ext_k");
    for (int i = 1; i <= 4; i++) cyc(1, 3, 0, 0, 1, 8'h01, 0, 32'h0, "ext_first");
    cyc(1, 3, 1, 32'h02, 1, 8'h03, 1, 32'h1, "ext_k5");
    for (int i = 6; i <= 14; i++) cyc(1, 3, 0, 0, 1, 8'h03, 1, 32'h3, "ext_both");
    cyc(1, 3, 0, 0, 1, 8'h00, 1, 32'h3, "ext_k15");
    cyc(1, 3, 0, 0, 1, 8'h00, 1, 32'h0, "ext_idle");

    // data write mid-pulse and pulse write on terminal count
    cyc(1, 2, 1, 32'd2, 1, 8'h00, 0, 32'h0, "len2_wr");
    cyc(1, 3, 1, 32'h01, 1, 8'h01, 0, 32'h0, "tc_k");
    cyc(1, 0, 1, 32'hF0, 1, 8'hF1, 0, 32'h0, "tc_data");
    cyc(1, 3, 1, 32'h04, 1, 8'hF5, 1, 32'h1, "tc_restart");
    cyc(1, 3, 0, 0, 1, 8'hF5, 1, 32'h5, "tc_hold");
    cyc(1, 3, 0, 0, 1, 8'hF0, 1, 32'h5, "tc_end");
    cyc(1, 3, 0, 0, 1, 8'hF0, 1, 32'h0, "tc_idle");

    // pulses that must do nothing
    cyc(1, 2, 1, 32'd0, 1, 8'hF0, 0, 32'h0, "len0_wr");
    cyc(1, 3, 1, 32'hFF, 1, 8'hF0, 0, 32'h0, "len0_pulse");
    cyc(1, 3, 0, 0, 1, 8'hF0, 1, 32'h0, "len0_mask");
    cyc(1, 2, 1, 32'd3, 1, 8'hF0, 0, 32'h0, "len3_wr");
    cyc(1, 3, 1, 32'h00, 1, 8'hF0, 0, 32'h0, "zero_pulse");
    cyc(1, 3, 0, 0, 1, 8'hF0, 1, 32'h0, "zero_mask");

    // reset aborts a long pulse
    cyc(1, 2, 1, 32'd100, 1, 8'hF0, 0, 32'h0, "len100_wr");
    cyc(1, 3, 1, 32'h01, 1, 8'hF1, 0, 32'h0, "long_k");
    for (int i = 0; i < 5; i++) cyc(1, 3, 0, 0, 1, 8'hF1, 1, 32'h1, "long_run");
    cyc(0, 3, 0, 0, 1, 8'h5A, 1, 32'h0, "abort");
    for (int i = 0; i < 110; i++) cyc(1, 3, 0, 0, 1, 8'h5A, 1, 32'h0, "post_abort");
    cyc(1, 2, 0, 0, 1, 8'h5A, 1, 32'd1000, "post_len");
    cyc(1, 0, 0, 0, 1, 8'h5A, 1, 32'h5A, "post_data");

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/my_nios_pio_out.md
# my_nios_pio_out

Avalon-MM slave output PIO for the `my_nios` Nios II system, the write-direction counterpart of the existing input PIOs. It drives an 8-bit `out_port`, typically the CYC1000 LEDs, from a CPU-writable data register. It supports atomic bit set/clear and a hardware one-shot "pulse" function that inverts selected bits for a programmable number of clocks without CPU involvement. It sits on the system interconnect beside the other PIO slaves, with read latency 1 and no waitrequest.

## Interface

- `DATA_WIDTH`, 8: width of `out_port` and the data register (1..32).
- `RESET_VALUE`, 0: value of the data register after reset.
- `PULSE_LEN_RESET`, 16'd1000: value of the pulse-length register after reset.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `address`  in  3  word address within the slave.
- `chipselect`  in  1  slave selected.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `out_port`  out  DATA_WIDTH  output pins, registered.

## Operation

Register map (word addresses):
- 0 DATA: R/W. A write loads `writedata[DATA_WIDTH-1:0]`. A read returns the data register, not the pins.
- 1 reserved: reads 0; writes are ignored.
- 2 PULSE_LEN: R/W, bits [15:0]. Upper bits read 0.
- 3 PULSE: a write starts or extends a pulse on the bits set in `writedata`. A read returns the active pulse mask.
- 4 OUTSET: write only. `data <= data | wd`. Reads 0.
- 5 OUTCLEAR: write only. `data <= data & ~wd`. Reads 0.
- 6, 7: reserved; read 0, writes ignored.

Output and pulse behaviour:
- `out_port = data_reg ^ pulse_mask`, registered.
- Pulse engine states:
  - IDLE: mask is 0.
  - ACTIVE: mask is nonzero; a 16-bit down-counter `cnt` is running.
- Write to PULSE with PULSE_LEN != 0 and nonzero data:
  - `mask <= mask | wd`
  - `cnt <= PULSE_LEN`
  - Go to ACTIVE.
  - A write during ACTIVE ORs in the new bits and restarts the full count for all active bits.
- Write to PULSE with PULSE_LEN == 0 or `wd` == 0: no effect.
- In ACTIVE with no PULSE write:
  - `cnt` decrements.
  - When `cnt == 1`, mask clears and the engine goes to IDLE.
- Writes to PULSE_LEN during ACTIVE affect only later pulses.
- DATA, OUTSET and OUTCLEAR writes during ACTIVE update `data_reg` immediately; pulsed bits stay inverted relative to the new value.
- Reset during ACTIVE aborts the pulse.

## Timing

- Reset (sampled at a rising edge with `reset_n == 0`) values:
  - `readdata` = 0
  - `data_reg` = RESET_VALUE
  - `out_port` = RESET_VALUE
  - `pulse_mask` = 0
  - `cnt` = 0
  - PULSE_LEN = PULSE_LEN_RESET
- Write latency:
  - A write sampled at edge k is visible on `out_port` after edge k.
  - A pulse started at edge k inverts the bits after edge k and restores them after edge k+PULSE_LEN. The inversion therefore lasts exactly PULSE_LEN cycles.
- Read latency:
  - `readdata` is registered every cycle from the `address` mux, regardless of `chipselect`.
  - Data for the address at edge k is valid after edge k.
  - The read of a register written at the same edge returns the pre-write value.
- Simultaneous events:
  - There is only one write per cycle, so there are no intra-register conflicts.
  - A PULSE write on the same edge as terminal count reloads the counter and keeps ACTIVE (write wins).

## Structure

- Shared package `my_nios_pio_pkg`:
  - Address constants: ADDR_DATA=0, ADDR_PULSE_LEN=2, ADDR_PULSE=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - Pulse state typedef {IDLE, ACTIVE}.
  - PULSE_LEN width constant 16.
- Sub-module `my_nios_pio_pulse_timer`:
  - Contains the mask, counter and state.
  - Inputs: start, start_mask, len.
  - Output: mask.
- The top level holds the register decode, `data_reg`, the readdata mux and the `out_port` register.

## Test plan

- Reset with RESET_VALUE=8'h5A → `out_port`=8'h5A, `readdata`=0, PULSE_LEN reads 1000.
- Write DATA=8'h0F, then OUTSET=8'hC0, then OUTCLEAR=8'h03 → `out_port` sequence 0F, CF, CC; reading address 0 returns 32'h000000CC one cycle after the address is presented.
- PULSE_LEN=4, DATA=8'h00, PULSE write 8'h01 at edge k → `out_port[0]`=1 for exactly edges k..k+3, back to 0 after k+4; reading address 3 during the pulse returns 1.
- PULSE_LEN=10, PULSE 8'h01 at edge k, PULSE 8'h02 at edge k+5 → bits 0 and 1 are both high until after edge k+15, then both clear together.
- PULSE_LEN=0, PULSE write 8'hFF → no change on `out_port`, mask reads 0.
- PULSE_LEN=100, start pulse, assert `reset_n`=0 for one edge mid-pulse → `out_port`=RESET_VALUE, mask 0, no residual pulse afterwards.
